// File: rtl/digital_clock_ctrl.sv
// HH:MM:SS clock with one-second prescaler and a two-button set interface.
// Buttons are synchronized and debounced; mode steps RUN -> SET_HR -> SET_MIN -> RUN.
module digital_clock_ctrl #(
    parameter int unsigned TICK_DIV     = 25000000,
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        btn_mode_i,
    input  logic        btn_inc_i,
    output logic [5:0]  sec_o,
    output logic [5:0]  min_o,
    output logic [5:0]  hr_o,
    output logic [1:0]  mode_o,
    output logic        tick_o,
    output logic [17:0] io_oeb_o
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYC - 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;

    // Button index 0 is mode, index 1 is increment.
    logic [1:0]         btn_raw;
    logic [1:0]         sync0_q, sync1_q;
    logic [1:0]         level_q, level_d;
    logic [1:0]         press_q, press_d;
    logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;

    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    hr_q, hr_d;
    logic [1:0]    mode_q, mode_d;
    logic          tick_q, tick_d;
    logic          advance;
    logic          mode_press, inc_press;

    assign btn_raw = {btn_inc_i, btn_mode_i};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        for (int b = 0; b < 2; b++) begin
            if (sync1_q[b] != level_q[b]) begin
                if (db_cnt_q[b] == DB_MAX) begin
                    level_d[b] = sync1_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DW'(1);
                end
            end
        end
        press_d = level_d & ~level_q;
    end

    assign mode_press = press_q[0];
    assign inc_press  = press_q[1];

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        advance = 1'b0;

        // Mode press has priority; a simultaneous inc press is dropped.
        case (mode_q)
            ST_RUN: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    advance = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (mode_press) begin
                    mode_d  = ST_SET_HR;
                    presc_d = '0;
                end
            end
            ST_SET_HR: begin
                presc_d = '0;
                if (mode_press) begin
                    mode_d = ST_SET_MIN;
                end else if (inc_press) begin
                    hr_d = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
                end
            end
            ST_SET_MIN: begin
                presc_d = '0;
                if (mode_press) begin
                    mode_d = ST_RUN;
                    sec_d  = 6'd0;
                end else if (inc_press) begin
                    min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                end
            end
            default: begin
                mode_d  = ST_RUN;
                presc_d = '0;
            end
        endcase

        if (advance) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d = 6'd0;
                    hr_d  = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end

        // Registered so tick_o is high during the cycle the prescaler holds its maximum.
        tick_d = (mode_d == ST_RUN) && (presc_d == PRESC_MAX);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync0_q  <= '0;
            sync1_q  <= '0;
            level_q  <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
            presc_q  <= '0;
            sec_q    <= '0;
            min_q    <= '0;
            hr_q     <= '0;
            mode_q   <= ST_RUN;
            tick_q   <= 1'b0;
        end else begin
            sync0_q  <= btn_raw;
            sync1_q  <= sync0_q;
            level_q  <= level_d;
            press_q  <= press_d;
            db_cnt_q <= db_cnt_d;
            presc_q  <= presc_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hr_q     <= hr_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
        end
    end

    assign sec_o    = sec_q;
    assign min_o    = min_q;
    assign hr_o     = hr_q;
    assign mode_o   = mode_q;
    assign tick_o   = tick_q;
    assign io_oeb_o = '0;

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Bench for digital_clock_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a time-of-day reference model.
module tb_digital_clock_ctrl;

    localparam int TD = 4;
    localparam int DB = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bm  = 1'b1;
    logic        bi  = 1'b1;
    logic [5:0]  sec_o, min_o, hr_o;
    logic [1:0]  mode_o;
    logic        tick_o;
    logic [17:0] io_oeb_o;

    digital_clock_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYC(DB)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .btn_mode_i (bm),
        .btn_inc_i  (bi),
        .sec_o      (sec_o),
        .min_o      (min_o),
        .hr_o       (hr_o),
        .mode_o     (mode_o),
        .tick_o     (tick_o),
        .io_oeb_o   (io_oeb_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Inputs as seen by the DUT at each rising edge.
    logic cap_rst, cap_bm, cap_bi;
    always @(posedge clk) begin
        cap_rst <= rst;
        cap_bm  <= bm;
        cap_bi  <= bi;
    end

    // Reference model: time kept as seconds of day, buttons as sample histories.
    int m_sec, m_min, m_hr, m_mode, m_presc, m_tick;
    bit m_s0 [2];
    bit m_s1 [2];
    bit m_lvl [2];
    bit m_pend [2];
    bit m_hist [2][DB];
    bit model_on = 1'b0;
    int tick_total = 0;

    task automatic advance_second();
        int t;
        t = (m_hr * 3600 + m_min * 60 + m_sec + 1) % 86400;
        m_hr  = t / 3600;
        m_min = (t / 60) % 60;
        m_sec = t % 60;
    endtask

    task automatic model_step();
        bit pm, pi, differ;
        bit btn_now [2];
        if (cap_rst) begin
            m_sec = 0; m_min = 0; m_hr = 0; m_mode = 0; m_presc = 0; m_tick = 0;
            for (int b = 0; b < 2; b++) begin
                m_s0[b] = 0; m_s1[b] = 0; m_lvl[b] = 0; m_pend[b] = 0;
                for (int k = 0; k < DB; k++) m_hist[b][k] = 0;
            end
            model_on = 1'b1;
            return;
        end
        if (!model_on) return;
        pm = m_pend[0];
        pi = m_pend[1];
        btn_now[0] = cap_bm;
        btn_now[1] = cap_bi;
        // Debounced level flips once the last DB synchronized samples all disagree with it.
        for (int b = 0; b < 2; b++) begin
            for (int k = DB - 1; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = m_s1[b];
            differ = 1'b1;
            for (int k = 0; k < DB; k++) if (m_hist[b][k] == m_lvl[b]) differ = 1'b0;
            m_pend[b] = 1'b0;
            if (differ) begin
                m_lvl[b]  = ~m_lvl[b];
                m_pend[b] = m_lvl[b];
            end
            m_s1[b] = m_s0[b];
            m_s0[b] = btn_now[b];
        end
        case (m_mode)
            0: begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    advance_second();
                end else begin
                    m_presc++;
                end
                if (pm) begin
                    m_mode  = 1;
                    m_presc = 0;
                end
            end
            1: begin
                if (pm) m_mode = 2;
                else if (pi) m_hr = (m_hr + 1) % 24;
            end
            default: begin
                if (pm) begin
                    m_mode  = 0;
                    m_sec   = 0;
                    m_presc = 0;
                end else if (pi) begin
                    m_min = (m_min + 1) % 60;
                end
            end
        endcase
        m_tick = (m_mode == 0 && m_presc == TD - 1) ? 1 : 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
            if (model_on) begin
                check("sec", int'(sec_o), m_sec);
                check("min", int'(min_o), m_min);
                check("hr", int'(hr_o), m_hr);
                check("mode", int'(mode_o), m_mode);
                check("tick", int'(tick_o), m_tick);
                check("oeb", int'(io_oeb_o), 0);
                if (tick_o) tick_total++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; bm = 1'b0; bi = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic press(input bit is_mode);
        if (is_mode) bm = 1'b1; else bi = 1'b1;
        cyc(DB + 4);
        bm = 1'b0; bi = 1'b0;
        cyc(DB + 4);
    endtask

    task automatic wait_mode(input int exp, input string tag);
        for (int i = 0; i < 30; i++) begin
            cyc(1);
            if (int'(mode_o) == exp) break;
        end
        check(tag, int'(mode_o), exp);
    endtask

    initial begin
        int ticks, t0;
        // Reset with both buttons held high.
        cyc(3);
        check("rst_sec", int'(sec_o), 0);
        check("rst_min", int'(min_o), 0);
        check("rst_hr", int'(hr_o), 0);
        check("rst_mode", int'(mode_o), 0);
        check("rst_tick", int'(tick_o), 0);
        rst = 1'b0;
        wait_mode(1, "held_mode_press");
        cyc(10);
        check("single_press", int'(mode_o), 1);
        check("inc_in_run_ignored", int'(hr_o), 0);
        bm = 1'b0; bi = 1'b0;
        cyc(10);

        // Free-running seconds.
        do_reset();
        ticks = 0;
        for (int i = 0; i < 240; i++) begin
            cyc(1);
            if (tick_o) ticks++;
        end
        check("run_ticks", ticks, 60);
        check("run_sec", int'(sec_o), 0);
        check("run_min", int'(min_o), 1);

        // Set 23:59 and roll over to midnight.
        do_reset();
        press(1'b1);
        repeat (23) press(1'b0);
        check("set_hr23", int'(hr_o), 23);
        press(1'b1);
        repeat (59) press(1'b0);
        check("set_min59", int'(min_o), 59);
        bm = 1'b1;
        wait_mode(0, "back_to_run");
        bm = 1'b0;
        check("run_sec_cleared", int'(sec_o), 0);
        check("first_cycle_no_tick", int'(tick_o), 0);
        for (int i = 0; i < 240; i++) begin
            cyc(1);
            check("tick_phase", int'(tick_o), (i % 4 == 2) ? 1 : 0);
        end
        check("midnight_hr", int'(hr_o), 0);
        check("midnight_min", int'(min_o), 0);
        check("midnight_sec", int'(sec_o), 0);

        // Hour wrap in SET_HR with no ticks.
        do_reset();
        press(1'b1);
        t0 = tick_total;
        repeat (25) press(1'b0);
        check("hr_wrap", int'(hr_o), 1);
        check("set_no_tick", tick_total - t0, 0);

        // Glitch rejection and simultaneous presses.
        bi = 1'b1;
        cyc(1);
        bi = 1'b0;
        cyc(DB + 6);
        check("glitch_hr", int'(hr_o), 1);
        bm = 1'b1; bi = 1'b1;
        cyc(DB + 4);
        bm = 1'b0; bi = 1'b0;
        cyc(DB + 4);
        check("simul_mode", int'(mode_o), 2);
        check("simul_hr", int'(hr_o), 1);

        // Reset in SET_MIN.
        repeat (30) press(1'b0);
        check("min30", int'(min_o), 30);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_mode", int'(mode_o), 0);
        check("midrst_hr", int'(hr_o), 0);
        check("midrst_min", int'(min_o), 0);
        check("midrst_sec", int'(sec_o), 0);

        // Random button traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bm  = 1'($urandom_range(0, 1));
            bi  = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 60) == 0);
            cyc(rst ? 1 : int'($urandom_range(1, 8)));
            rst = 1'b0;
        end
        bm = 1'b0; bi = 1'b0;
        cyc(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/digital_clock_ctrl.md
DIGITAL_CLOCK_CTRL -- requirements
Module: digital_clock_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 25000000: wb_clk_i cycles per one-second tick, minimum 2.
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 16: consecutive stable synchronized cycles needed to accept a button level change, minimum 1.
REQ-003 Port wb_clk_i SHALL be input, width 1: the single clock; all state SHALL be on its rising edge.
REQ-004 Port wb_rst_i SHALL be input, width 1: reset, synchronous, active-high.
REQ-005 Port btn_mode_i SHALL be input, width 1: asynchronous mode button, active-high.
REQ-006 Port btn_inc_i SHALL be input, width 1: asynchronous increment button, active-high.
REQ-007 Port sec_o SHALL be output, width 6: seconds, binary 0..59.
REQ-008 Port min_o SHALL be output, width 6: minutes, binary 0..59.
REQ-009 Port hr_o SHALL be output, width 6: hours, binary 0..23.
REQ-010 Port mode_o SHALL be output, width 2: current state, encoded 0=RUN, 1=SET_HR, 2=SET_MIN.
REQ-011 Port tick_o SHALL be output, width 1: one-cycle pulse per one-second tick.
REQ-012 Port io_oeb_o SHALL be output, width 18: pad output enables, active-low, constant 0.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Debounce: the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYC consecutive cycles; any disagreement-free cycle SHALL reset the count.
REQ-015 Press pulse: a 0->1 transition of a debounced level SHALL produce exactly one single-cycle internal press; release SHALL produce nothing.
REQ-016 The state machine SHALL have states RUN, SET_HR and SET_MIN; a mode press SHALL step RUN->SET_HR->SET_MIN->RUN on the next edge.
REQ-017 If mode and inc presses occur in the same cycle, mode SHALL win and inc SHALL be discarded.
REQ-018 RUN prescaler: it SHALL count 0..TICK_DIV-1; on the cycle it holds TICK_DIV-1, it SHALL wrap to 0, tick_o SHALL be 1, and the time SHALL advance by one second on that same edge.
REQ-019 Carry: sec 59->0 SHALL increment min; min 59 with sec 59 SHALL wrap min to 0 and increment hr; 23:59:59 SHALL advance to 00:00:00.
REQ-020 In SET_HR and SET_MIN, the prescaler and tick_o SHALL be held at 0 and the time SHALL not advance.
REQ-021 In SET_HR, an inc press SHALL increment hr modulo 24; in SET_MIN, it SHALL increment min modulo 60; other fields SHALL be unchanged.
REQ-022 An inc press in RUN SHALL be ignored.
REQ-023 On the SET_MIN->RUN transition, sec and the prescaler SHALL be cleared to 0, so the first tick follows exactly TICK_DIV cycles later.
REQ-024 All outputs SHALL be registered; no combinational path SHALL run from the button inputs to the outputs.
REQ-025 Out-of-range values (sec/min >59, hr >23) SHALL never appear on the outputs.

Reset
REQ-026 While wb_rst_i=1 at a rising edge, the block SHALL load: sec_o=min_o=hr_o=0, mode_o=0 (RUN), tick_o=0, prescaler=0, synchronizers, debounced levels and debounce counters=0, io_oeb_o=0.
REQ-027 Reset SHALL take priority over all other events, including in SET states and during a tick cycle.
REQ-028 A button held high through reset release SHALL produce a press only after its debounce completes (debounced level starts at 0).

Verification
Scenarios use TICK_DIV=4 and DEBOUNCE_CYC=2.
REQ-029 Reset: assert wb_rst_i 3 cycles with both buttons high -> all outputs 0, mode_o=0; after release, exactly one mode press -> mode_o=1.
REQ-030 Run: from reset, 240 cycles -> tick_o pulses every 4th cycle, sec counts 0..59 and wraps, min_o=1, sec_o=0.
REQ-031 Set and rollover: mode press; 23 inc presses -> hr_o=23; mode press; 59 inc presses -> min_o=59; mode press -> mode_o=0, sec_o=0; 240 cycles later -> 00:00:00 with no tick for the first 3 cycles.
REQ-032 Hour wrap: in SET_HR, 25 inc presses from 0 -> hr_o=1; tick_o stays 0 throughout.
REQ-033 Glitch/simultaneous: a 1-cycle btn_inc_i pulse -> no change; mode and inc pressed in the same cycle in SET_HR -> mode_o=2, hr_o unchanged.
REQ-034 Reset mid-operation: wb_rst_i in SET_MIN with min_o=30 -> next cycle mode_o=0 and all fields 0.
